serial_rx_fifo: RTL

//  Receive side of the console serial link: deserialises 8N1 async frames from the host TX line.

---
 rtl/serial_rx_fifo_if.sv | 24 ++
 rtl/serial_rx_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_rx_fifo_if.sv
// Read-side bundle of the console serial receiver.
// The FIFO drives head data and fill level; the reader pops.
interface serial_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  rd_en;
    logic [7:0]            rd_data;
    logic                  rd_valid;
    logic [DEPTH_LOG2:0]   count;

    modport master (
        input  rd_en,
        output rd_data,
        output rd_valid,
        output count
    );

    modport slave (
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  count
    );
endinterface

// File: rtl/serial_rx_fifo.sv
// 8N1 console receiver feeding a show-ahead byte FIFO.
// Drives RTS back to the host and keeps sticky line error flags.
module serial_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4,
    parameter int RTS_THRESH = 12
) (
    input  logic               clk,
    input  logic               N_RESET,
    input  logic               rxd,
    serial_rx_fifo_if.master   rd,
    output logic               rts,
    input  logic               err_clr,
    output logic               frame_err,
    output logic               overrun
);

    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int DW    = $clog2(DIV + 1);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PW    = DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic            rx_m;
    logic            rx_s;
    logic            rx_q;
    logic [DW-1:0]   div_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;

    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    logic tick;
    logic stop_ok;
    logic stop_bad;
    logic full;
    logic pop;
    logic push_ok;
    logic ovr_set;

    // Divider counts down to 1; the sample is taken on that clock.
    assign tick     = (div_cnt == DW'(1));
    assign stop_ok  = (state == S_STOP) && tick && rx_s;
    assign stop_bad = (state == S_STOP) && tick && !rx_s;
    assign full     = (cnt == CW'(DEPTH));
    assign pop      = rd.rd_en && (cnt != '0);
    assign push_ok  = stop_ok && (!full || pop);
    assign ovr_set  = stop_ok && full && !pop;

    always_ff @(posedge clk or negedge N_RESET) begin
        if (!N_RESET) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            rx_m <= rxd;
            rx_s <= rx_m;
            rx_q <= rx_s;
            unique case (state)
                S_IDLE: begin
                    if (rx_q && !rx_s) begin
                        div_cnt <= DW'(DIV / 2);
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        div_cnt <= DW'(DIV);
                        bit_cnt <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        div_cnt <= div_cnt - DW'(1);
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift   <= {rx_s, shift[7:1]};
                        div_cnt <= DW'(DIV);
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= S_STOP;
                    end else begin
                        div_cnt <= div_cnt - DW'(1);
                    end
                end
                S_STOP: begin
                    if (tick)
                        state <= rx_s ? S_IDLE : S_BREAK;
                    else
                        div_cnt <= div_cnt - DW'(1);
                end
                S_BREAK: begin
                    if (rx_s)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (push_ok && !pop)
            cnt_nxt = cnt + CW'(1);
        else if (pop && !push_ok)
            cnt_nxt = cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge N_RESET) begin
        if (!N_RESET) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rts    <= 1'b1;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt_nxt;
            rts <= (cnt_nxt >= CW'(RTS_THRESH));
        end
    end

    // A set event in the same cycle as err_clr keeps the flag high.
    always_ff @(posedge clk or negedge N_RESET) begin
        if (!N_RESET) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (stop_bad)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
            if (ovr_set)
                overrun <= 1'b1;
            else if (err_clr)
                overrun <= 1'b0;
        end
    end

    assign rd.rd_data  = mem[rd_ptr];
    assign rd.rd_valid = (cnt != '0);
    assign rd.count    = cnt;

endmodule
